// File: rtl/hax_elevator_scheduler.sv
// SCAN elevator call scheduler: collects floor calls into a pending bitmap and
// dispatches one target at a time to the car datapath with a door-dwell pause.
module hax_elevator_scheduler #(
    parameter int unsigned NUM_FLOORS   = 10,
    parameter int unsigned DWELL_CYCLES = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [3:0]            req_floor,
    input  logic [3:0]            cur_floor,
    input  logic                  arrived,
    input  logic                  target_ready,
    output logic                  target_valid,
    output logic [3:0]            target_floor,
    output logic                  busy,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned FLOOR_W = 4;
    localparam int unsigned CNT_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, TRAVEL, DWELL} state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dir_reg_q, dir_reg_d;
    logic                  tvalid_q, tvalid_d;
    logic                  busy_q, busy_d;
    logic                  dir_up_q, dir_up_d;
    logic                  dir_down_q, dir_down_d;

    logic                  pend_hit, req_ok;
    logic                  up_found, dn_found, sel_dir;
    logic [FLOOR_W-1:0]    up_floor, dn_floor, sel_floor;

    // Priority search: nearest pending floor above and below the car.
    always_comb begin
        pend_hit = 1'b0;
        up_found = 1'b0;
        up_floor = '0;
        dn_found = 1'b0;
        dn_floor = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending_q[i] && FLOOR_W'(i) == req_floor) pend_hit = 1'b1;
            if (pending_q[i] && FLOOR_W'(i) < cur_floor) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pending_q[i] && FLOOR_W'(i) > cur_floor) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        req_ok = req_valid && (32'(req_floor) < NUM_FLOORS) && (req_floor != cur_floor) && !pend_hit;
    end

    // SCAN choice; falls back to the current floor if that is the only call left.
    always_comb begin
        sel_floor = cur_floor;
        sel_dir   = dir_reg_q;
        if (dir_reg_q) begin
            if (up_found) begin
                sel_floor = up_floor;
            end else if (dn_found) begin
                sel_floor = dn_floor;
                sel_dir   = 1'b0;
            end
        end else begin
            if (dn_found) begin
                sel_floor = dn_floor;
            end else if (up_found) begin
                sel_floor = up_floor;
                sel_dir   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        dir_reg_d = dir_reg_q;

        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (req_ok && FLOOR_W'(i) == req_floor) pending_d[i] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    target_d  = sel_floor;
                    dir_reg_d = sel_dir;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (target_ready) state_d = TRAVEL;
            end
            TRAVEL: begin
                if (arrived && cur_floor == target_q) begin
                    // Arrival clear is applied after the request set so it wins.
                    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
                        if (FLOOR_W'(i) == target_q) pending_d[i] = 1'b0;
                    end
                    cnt_d   = CNT_W'(DWELL_CYCLES - 1);
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    if (|pending_q) begin
                        target_d  = sel_floor;
                        dir_reg_d = sel_dir;
                        state_d   = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d   = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
        dir_up_d   = (state_d == ISSUE || state_d == TRAVEL) && (target_d > cur_floor);
        dir_down_d = (state_d == ISSUE || state_d == TRAVEL) && (target_d < cur_floor);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            target_q   <= '0;
            cnt_q      <= '0;
            dir_reg_q  <= 1'b1;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            dir_reg_q  <= dir_reg_d;
            tvalid_q   <= tvalid_d;
            busy_q     <= busy_d;
            dir_up_q   <= dir_up_d;
            dir_down_q <= dir_down_d;
        end
    end

    assign target_valid = tvalid_q;
    assign target_floor = target_q;
    assign busy         = busy_q;
    assign dir_up       = dir_up_q;
    assign dir_down     = dir_down_q;
    assign pending      = pending_q;

endmodule
